// File: rtl/data_ram_if.sv
// Data-port bus between the MEM stage (master) and the data RAM responder (slave).
// req/addr/calWE/wdata go towards the responder; ready/rvalid/RAMtmp/busy come back.
interface data_ram_if;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  calWE;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] RAMtmp;
    logic        busy;

    modport master (output req, addr, calWE, wdata, input ready, rvalid, RAMtmp, busy);
    modport slave  (input req, addr, calWE, wdata, output ready, rvalid, RAMtmp, busy);
endinterface

// File: rtl/data_ram_responder.sv
// Word-wide data RAM with lane write enables, programmable wait states and a
// req/ready/rvalid handshake; returns the merged addressed word on every access.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    data_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, nextState;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   latIdx;
    logic [3:0]              latWE;
    logic [31:0]             latData;
    logic [31:0]             ramTmpQ;
    logic [31:0]             mem [DEPTH];

    logic                    accept, commit;
    logic [ADDR_WIDTH-1:0]   opIdx;
    logic [3:0]              opWE;
    logic [31:0]             opData, oldWord, merged;
    logic                    unusedAddrBits;

    assign unusedAddrBits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

    assign accept = (state == IDLE) && bus.req;
    assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

    // Zero-wait commits happen on the accept edge, so operands bypass the latches.
    assign opIdx  = (state == IDLE) ? bus.addr[ADDR_WIDTH+1:2] : latIdx;
    assign opWE   = (state == IDLE) ? bus.calWE : latWE;
    assign opData = (state == IDLE) ? bus.wdata : latData;
    assign oldWord = mem[opIdx];

    for (genvar i = 0; i < 4; i++) begin : gLane
        assign merged[8*i +: 8] = opWE[i] ? opData[8*i +: 8] : oldWord[8*i +: 8];
    end

    // State register, wait counter, operand latches and response word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            latIdx  <= '0;
            latWE   <= 4'd0;
            latData <= 32'h0;
            ramTmpQ <= 32'h0;
        end else begin
            state <= nextState;
            if (accept) begin
                latIdx  <= bus.addr[ADDR_WIDTH+1:2];
                latWE   <= bus.calWE;
                latData <= bus.wdata;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && !commit) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) ramTmpQ <= merged;
        end
    end

    // Array is never cleared; rst gating keeps an aborted access from landing.
    always_ff @(posedge clk) begin
        if (commit && !rst) mem[opIdx] <= merged;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.ready  = 1'b0;
        bus.busy   = 1'b1;
        bus.rvalid = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                bus.busy  = 1'b0;
            end
            RESP: bus.rvalid = 1'b1;
            default: ;
        endcase
    end

    assign bus.RAMtmp = ramTmpQ;
endmodule

// File: tb/tb_data_ram_responder.sv
// Directed checks of the data RAM responder: lane merges, latency, handshake,
// reset abort and word-index wrap, on a WAIT_CYCLES=1 and a WAIT_CYCLES=0 instance.
module tb_data_ram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecCnt = 0;
    int   errCnt = 0;

    always #5 clk = ~clk;

    data_ram_if bus1 ();
    data_ram_if bus0 ();

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // One access on dut1; inputs are scrambled after accept to prove operands are frozen.
    task automatic access(input string tag, input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] d, input logic [31:0] exp);
        int n = 0;
        int guard = 0;
        while (!bus1.ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus1.req = 1'b1; bus1.addr = a; bus1.calWE = we; bus1.wdata = d;
        @(posedge clk);
        #1;
        bus1.req = 1'b0; bus1.addr = 32'h0000_0FFC; bus1.calWE = 4'hF; bus1.wdata = 32'h5A5A_5A5A;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus1.rvalid) break;
        end
        chk({tag, " lat"}, 32'(n), 32'd2);
        chk({tag, " data"}, bus1.RAMtmp, exp);
        bus1.calWE = 4'h0;
    endtask

    initial begin
        int rv, rdy;
        bus1.req = 1'b0; bus1.addr = 32'h0; bus1.calWE = 4'h0; bus1.wdata = 32'h0;
        bus0.req = 1'b0; bus0.addr = 32'h0; bus0.calWE = 4'h0; bus0.wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(bus1.ready), 32'd1);
        chk("rst busy", 32'(bus1.busy), 32'd0);
        chk("rst rvalid", 32'(bus1.rvalid), 32'd0);
        chk("rst RAMtmp", bus1.RAMtmp, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        access("wr word", 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold RAMtmp", bus1.RAMtmp, 32'hDEAD_BEEF);
        access("rd word", 32'h10, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        access("wr byte", 32'h10, 4'b0100, 32'h00AA_0000, 32'hDEAA_BEEF);
        access("rd byte", 32'h10, 4'b0000, 32'h0, 32'hDEAA_BEEF);
        access("wr half", 32'h10, 4'b0011, 32'h0000_1234, 32'hDEAA_1234);
        access("wr off3", 32'h13, 4'b0001, 32'h0000_0055, 32'hDEAA_1255);
        access("rd off3", 32'h10, 4'b0000, 32'h0, 32'hDEAA_1255);

        // Continuous req on WAIT_CYCLES=1: 3-cycle period over 9 cycles
        @(negedge clk);
        bus1.req = 1'b1; bus1.addr = 32'h40; bus1.calWE = 4'b0000;
        rv = 0; rdy = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rv  += int'(bus1.rvalid);
            rdy += int'(bus1.ready);
        end
        bus1.req = 1'b0;
        chk("hs1 rvalids", 32'(rv), 32'd3);
        chk("hs1 readys", 32'(rdy), 32'd3);

        // WAIT_CYCLES=0: write, then continuous reads 2 cycles apart
        bus0.req = 1'b1; bus0.addr = 32'h8; bus0.calWE = 4'hF; bus0.wdata = 32'h1357_9BDF;
        @(negedge clk);
        bus0.calWE = 4'h0; bus0.wdata = 32'h0;
        chk("w0 rvalid", 32'(bus0.rvalid), 32'd1);
        chk("w0 data", bus0.RAMtmp, 32'h1357_9BDF);
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rv += int'(bus0.rvalid);
        end
        bus0.req = 1'b0;
        chk("hs0 rvalids", 32'(rv), 32'd4);
        chk("hs0 readback", bus0.RAMtmp, 32'h1357_9BDF);

        // Reset while waiting aborts the store
        access("wr zero", 32'h20, 4'b1111, 32'h0, 32'h0);
        access("rd nz", 32'h10, 4'b0000, 32'h0, 32'hDEAA_1255);
        while (!bus1.ready) @(negedge clk);
        bus1.req = 1'b1; bus1.addr = 32'h20; bus1.calWE = 4'hF; bus1.wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        bus1.req = 1'b0;
        chk("pre-abort busy", 32'(bus1.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort ready", 32'(bus1.ready), 32'd1);
        chk("abort busy", 32'(bus1.busy), 32'd0);
        chk("abort rvalid", 32'(bus1.rvalid), 32'd0);
        chk("abort RAMtmp", bus1.RAMtmp, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access("rd aborted", 32'h20, 4'b0000, 32'h0, 32'h0);

        // Word index wraps at 2**10 words
        access("wr wrap", 32'h1000, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);
        access("rd wrap", 32'h0, 4'b0000, 32'h0, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
